// File: rtl/rename_alloc_n.sv
// N-wide rename and ROB-id allocation stage: speculative RAT lookup with intra-group
// and commit bypass, consecutive ROB-id allocation, and a registered valid/ready output.
// Handshake: a group is accepted when in_valid && in_ready. The output group is held
// while out_valid && !out_ready, and it is replaced or dropped once out_ready is high.
module rename_alloc_n #(
  parameter int WIDTH     = 2,
  parameter int RPORTS    = 2,
  parameter int ARF_DEPTH = 32,
  parameter int ROB_DEPTH = 64,
  localparam int LW = $clog2(ARF_DEPTH),
  localparam int RW = $clog2(ROB_DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_lane_valid,
  input  logic [WIDTH*RPORTS*LW-1:0]     in_src_areg,
  input  logic [WIDTH-1:0]               in_dst_we,
  input  logic [WIDTH*LW-1:0]            in_dst_areg,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_lane_valid,
  output logic [WIDTH*RPORTS*RW-1:0]     out_src_robid,
  output logic [WIDTH*RPORTS-1:0]        out_src_renamed,
  output logic [WIDTH*RW-1:0]            out_dst_robid,
  output logic [WIDTH-1:0]               out_dst_we,
  input  logic [WIDTH-1:0]               cmt_valid,
  input  logic [WIDTH-1:0]               cmt_we,
  input  logic [WIDTH*LW-1:0]            cmt_areg,
  input  logic [WIDTH*RW-1:0]            cmt_robid,
  output logic [RW:0]                    rob_count
);

  logic              r_busy   [ARF_DEPTH];
  logic [RW-1:0]     r_rat_id [ARF_DEPTH];
  logic [RW-1:0]     r_tail;
  logic [RW:0]       r_count;
  logic              r_out_valid;
  logic [WIDTH-1:0]  r_out_lane_valid;
  logic [WIDTH*RPORTS*RW-1:0] r_out_src_robid;
  logic [WIDTH*RPORTS-1:0]    r_out_src_renamed;
  logic [WIDTH*RW-1:0]        r_out_dst_robid;
  logic [WIDTH-1:0]           r_out_dst_we;

  logic [RW-1:0]     w_lane_id [WIDTH];
  logic [WIDTH*RW-1:0] w_dst_robid;
  logic [RW:0]       w_alloc_cnt;
  logic [RW:0]       w_cmt_cnt;
  logic [RW:0]       w_free;
  logic [WIDTH-1:0]  w_dst_we;
  logic [WIDTH*RPORTS*RW-1:0] w_src_robid;
  logic [WIDTH*RPORTS-1:0]    w_src_ren;
  logic              w_accept;

  // Valid lanes get consecutive ids from the tail, compacted in lane order.
  always_comb begin
    w_alloc_cnt = '0;
    w_dst_robid = '0;
    w_cmt_cnt   = '0;
    for (int l = 0; l < WIDTH; l++) begin
      w_lane_id[l] = r_tail + w_alloc_cnt[RW-1:0];
      w_dst_robid[l*RW +: RW] = w_lane_id[l];
      w_dst_we[l] = in_lane_valid[l] & in_dst_we[l] & (in_dst_areg[l*LW +: LW] != '0);
      if (in_lane_valid[l]) w_alloc_cnt = w_alloc_cnt + (RW+1)'(1);
      if (cmt_valid[l]) w_cmt_cnt = w_cmt_cnt + (RW+1)'(1);
    end
  end

  always_comb begin
    w_src_robid = '0;
    w_src_ren   = '0;
    for (int l = 0; l < WIDTH; l++) begin
      for (int p = 0; p < RPORTS; p++) begin
        logic [LW-1:0] a;
        logic          hit;
        logic [RW-1:0] hid;
        a   = in_src_areg[(l*RPORTS+p)*LW +: LW];
        hit = 1'b0;
        hid = '0;
        // Ascending scan leaves the nearest lower producer lane in hid.
        for (int k = 0; k < l; k++) begin
          if (w_dst_we[k] && (in_dst_areg[k*LW +: LW] == a)) begin
            hit = 1'b1;
            hid = w_lane_id[k];
          end
        end
        if (a == '0) begin
          w_src_ren[l*RPORTS+p] = 1'b0;
        end else if (hit) begin
          w_src_ren[l*RPORTS+p]            = 1'b1;
          w_src_robid[(l*RPORTS+p)*RW +: RW] = hid;
        end else begin
          w_src_ren[l*RPORTS+p]            = r_busy[a];
          w_src_robid[(l*RPORTS+p)*RW +: RW] = r_rat_id[a];
          for (int c = 0; c < WIDTH; c++) begin
            if (cmt_valid[c] && cmt_we[c] && (cmt_areg[c*LW +: LW] == a) &&
                (cmt_robid[c*RW +: RW] == r_rat_id[a]))
              w_src_ren[l*RPORTS+p] = 1'b0;
          end
        end
      end
    end
  end

  assign w_free   = (RW+1)'(ROB_DEPTH) - r_count;
  assign in_ready = (!r_out_valid || out_ready) && !flush && !rst &&
                    (w_free >= (RW+1)'(WIDTH));
  assign w_accept = in_valid && in_ready;

  // Commit clears come first so a same-cycle rename write to the areg wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARF_DEPTH; i++) begin
        r_busy[i]   <= 1'b0;
        r_rat_id[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < ARF_DEPTH; i++) r_busy[i] <= 1'b0;
    end else begin
      for (int c = 0; c < WIDTH; c++) begin
        if (cmt_valid[c] && cmt_we[c] &&
            (r_rat_id[cmt_areg[c*LW +: LW]] == cmt_robid[c*RW +: RW]))
          r_busy[cmt_areg[c*LW +: LW]] <= 1'b0;
      end
      if (w_accept) begin
        for (int l = 0; l < WIDTH; l++) begin
          if (w_dst_we[l]) begin
            r_busy[in_dst_areg[l*LW +: LW]]   <= 1'b1;
            r_rat_id[in_dst_areg[l*LW +: LW]] <= w_lane_id[l];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_tail            <= '0;
      r_count           <= '0;
      r_out_valid       <= 1'b0;
      r_out_lane_valid  <= '0;
      r_out_src_robid   <= '0;
      r_out_src_renamed <= '0;
      r_out_dst_robid   <= '0;
      r_out_dst_we      <= '0;
    end else begin
      r_count <= r_count + (w_accept ? w_alloc_cnt : '0) - w_cmt_cnt;
      if (w_accept) begin
        r_tail            <= r_tail + w_alloc_cnt[RW-1:0];
        r_out_valid       <= 1'b1;
        r_out_lane_valid  <= in_lane_valid;
        r_out_src_robid   <= w_src_robid;
        r_out_src_renamed <= w_src_ren;
        r_out_dst_robid   <= w_dst_robid;
        r_out_dst_we      <= w_dst_we;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid       = r_out_valid;
  assign out_lane_valid  = r_out_lane_valid;
  assign out_src_robid   = r_out_src_robid;
  assign out_src_renamed = r_out_src_renamed;
  assign out_dst_robid   = r_out_dst_robid;
  assign out_dst_we      = r_out_dst_we;
  assign rob_count       = r_count;

endmodule
